evt_generator: RTL
==================

# evt_generator

Programmable event-strobe source: once started, it emits single-cycle `evt_out` pulses at a fixed interval of `period_in` clock cycles, for `burst_in` events or continuously. It is the driving end of the event-counting path. Its `evt_out` connects directly to an event counter's `evt_in` to produce known stimulus, sample ticks or paced triggers. It reports progress through `busy_out`, a `done_out` pulse and a running emitted-event count.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of `period_in`, `burst_in`, `evt_count_out` and the internal counters.

Ports:
- `clk_in`  in  1  sole clock; all logic is on its rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  request to begin a run; sampled only in IDLE.
- `stop_in`  in  1  abort the current run; has priority over everything except reset.
- `period_in`  in  CNT_WIDTH  number of cycles between events; latched on start; 0 is illegal.
- `burst_in`  in  CNT_WIDTH  number of events to emit; latched on start; 0 means continuous.
- `evt_out`  out  1  one-cycle event strobe (registered).
- `busy_out`  out  1  high while a run is in progress (registered).
- `done_out`  out  1  one-cycle pulse marking completion of a finite burst (registered).
- `evt_count_out`  out  CNT_WIDTH  number of events emitted in the current or last run (registered).

## Operation
- Two states: IDLE and RUN. Reset forces IDLE, sets all outputs to 0 and clears the internal phase counter.
- **IDLE, start accepted:** `start_in`=1, `stop_in`=0 and `period_in`≠0.
  - Latch `period_in` and `burst_in`.
  - Phase counter ← 0; `evt_count_out` ← 0; `busy_out` ← 1.
  - Go to RUN.
- **IDLE, start ignored:** `start_in` with `period_in`=0, or `start_in` and `stop_in` together. No state change, no `done_out`, and `evt_count_out` keeps its old value.
- **RUN, normal counting:** each edge with phase < period−1 increments phase and leaves `evt_out` at 0.
- **RUN, event edge:** an edge with phase = period−1 does the following:
  - phase ← 0; `evt_out` ← 1; `evt_count_out` ← `evt_count_out`+1.
  - Finite burst, and the new count equals the latched burst: also `busy_out` ← 0, `done_out` ← 1, go to IDLE.
  - Continuous mode: `evt_count_out` wraps from 2^CNT_WIDTH−1 to 0 and the run continues.
- **RUN, stop:** `stop_in`=1 sends the block to IDLE at that edge.
  - `busy_out` ← 0 and `evt_out` ← 0. Stop suppresses a coincident event.
  - No `done_out` pulse; `evt_count_out` holds.
- `start_in` in RUN is ignored, and changes on `period_in`/`burst_in` during RUN have no effect.
- `evt_count_out` holds its final value in IDLE until the next accepted start.
- `evt_out` and `done_out` are 0 on every edge not listed above.

## Timing
- The start is accepted at edge E0, and `busy_out` is high from E0.
- The first `evt_out` appears in the cycle after edge E_period, i.e. `period_in` cycles after E0.
- Subsequent events follow every `period_in` cycles; with period = 1, `evt_out` is high every cycle.
- On the final event of a finite burst, `evt_out`=1, `done_out`=1 and `busy_out`=0 all appear in the same cycle.
  - A new start can be accepted at the very next edge, which gives back-to-back bursts with no gap cycle beyond the period.
- Stop: `busy_out` is low in the cycle after the edge that sampled `stop_in`.
- Async reset mid-run: outputs go to 0 immediately, with no clock needed. After reset release, the block is in IDLE and needs a new start.

## Test plan
- Period 4, burst 3, start at E0 → `evt_out` high in the cycles after E4, E8 and E12. `done_out`=1 and `busy_out`=0 after E12, `evt_count_out`=3 held afterward.
- Period 1, burst 5 → `evt_out` high for 5 consecutive cycles, `done_out` coincident with the 5th. An immediate restart at the next edge with period 2, burst 1 gives one event 2 cycles later.
- Period 3, burst 0, run 30 cycles, then `stop_in` → 10 events and `evt_count_out`=10. Then `busy_out`=0, no `done_out`, no further events.
- `stop_in` on the same edge as phase = period−1 → no `evt_out` and the count is unchanged. Also: `start_in` with `period_in`=0 → stays IDLE and all outputs stay 0.
- `start_in` asserted mid-run with different `period_in` → spacing and burst are unchanged.
- Assert `rst_in` asynchronously between edges mid-run → all outputs 0 before the next edge; no events after release until a new start.

Source files
------------

// File: rtl/evt_generator.sv
// evt_generator: programmable event-strobe source.
// Once started it emits one-cycle evt_out pulses every period_in cycles, for
// burst_in events (burst_in = 0 runs until stop_in), and reports progress.
//
// Ports:
//   clk_in         rising-edge clock
//   rst_in         asynchronous active-high reset
//   start_in       begin a run (sampled only while idle)
//   stop_in        abort the current run; suppresses a coincident event
//   period_in      cycles between events, latched on start (0 rejects the start)
//   burst_in       events per run, latched on start (0 = continuous)
//   evt_out        one-cycle event strobe
//   busy_out       high while a run is in progress
//   done_out       one-cycle pulse on the final event of a finite burst
//   evt_count_out  events emitted in the current or last run
module evt_generator #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic [CNT_WIDTH-1:0] burst_in,
  output logic                 evt_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [CNT_WIDTH-1:0] evt_count_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0] phase_q, phase_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 evt_q, evt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_WIDTH-1:0] count_inc;
  logic                 phase_last;

  // Count after this event; wraps naturally in continuous mode.
  assign count_inc  = count_q + CNT_WIDTH'(1);
  assign phase_last = (phase_q == (period_q - CNT_WIDTH'(1)));

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      burst_q  <= '0;
      phase_q  <= '0;
      count_q  <= '0;
      evt_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      burst_q  <= burst_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      evt_q    <= evt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and output logic; strobes default low every cycle.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    burst_d  = burst_q;
    phase_d  = phase_q;
    count_d  = count_q;
    busy_d   = busy_q;
    evt_d    = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in && !stop_in && (period_in != '0)) begin
          period_d = period_in;
          burst_d  = burst_in;
          phase_d  = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_in) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (phase_last) begin
          phase_d = '0;
          evt_d   = 1'b1;
          count_d = count_inc;
          // Final event of a finite burst: evt, done and busy-drop coincide.
          if ((burst_q != '0) && (count_inc == burst_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign evt_out       = evt_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign evt_count_out = count_q;

endmodule
